// File: rtl/axi_rd_arb_pkg.sv
// Package for the AXI read-channel arbiter.
// Holds the FSM state encoding, the AXI constants used by the arbiter and its
// bench, and a helper that sizes the starvation counter.
package axi_rd_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AR_INST = 3'd1,
    ST_AR_DATA = 3'd2,
    ST_R_INST  = 3'd3,
    ST_R_DATA  = 3'd4
  } arb_state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Counter must hold 0..limit; a limit of 0 still needs one bit.
  function automatic int starve_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/axi_rd_arb_sel.sv
// Winner select for the read arbiter plus the data-starvation counter.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   inst_valid, data_valid  requester ARVALIDs
//   arb_en                  high while the arbiter is idle and may grant
//   grant_inst, grant_data  one-hot (or none) grant for this cycle
module axi_rd_arb_sel
  import axi_rd_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inst_valid,
  input  logic data_valid,
  input  logic arb_en,
  output logic grant_inst,
  output logic grant_data
);

  localparam int            CW    = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          force_data;

  // A limit of 0 means inst always wins; the counter never forces data.
  always_comb begin
    force_data = (STARVE_LIMIT != 0) && data_valid && (starve_cnt == LIMIT);
    grant_inst = arb_en && inst_valid && !force_data;
    grant_data = arb_en && data_valid && !grant_inst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_data) begin
      starve_cnt <= '0;
    end else if (grant_inst && data_valid && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter between the instruction and data caches on one AXI
// master. One burst is granted at a time; the grant is held until the last
// read beat is accepted, and R beats are steered only to the granted cache.
// Instruction reads win unless data has waited STARVE_LIMIT inst grants.
// Ports:
//   CLK, RSTN                   clock, async active-low reset
//   INST_AR* / DATA_AR*         requester AR channels (ARREADY is an output)
//   INST_R* / DATA_R*           requester R channels (data/resp/last broadcast)
//   M_AXI_AR* / M_AXI_R*        shared master AR/R channels
//   RD_ERR, RD_ERR_ADDR,        sticky error flag/address and its clear, only
//   RD_ERR_CLR                  present when ARB_ERR_CAPTURE_EN is defined
// Build option: `define ARB_ERR_CAPTURE_EN to add read-error capture.
//
// state      | meaning
// ST_IDLE    | no grant; winner selected and AR fields latched
// ST_AR_INST | inst request presented on master AR
// ST_AR_DATA | data request presented on master AR
// ST_R_INST  | R beats routed to inst until RLAST handshake
// ST_R_DATA  | R beats routed to data until RLAST handshake
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  CLK,
  input  logic                  RSTN,
`ifdef ARB_ERR_CAPTURE_EN
  output logic                  RD_ERR,
  output logic [ADDR_WIDTH-1:0] RD_ERR_ADDR,
  input  logic                  RD_ERR_CLR,
`endif
  input  logic [ADDR_WIDTH-1:0] INST_ARADDR,
  input  logic [7:0]            INST_ARLEN,
  input  logic [2:0]            INST_ARSIZE,
  input  logic [1:0]            INST_ARBURST,
  input  logic                  INST_ARVALID,
  output logic                  INST_ARREADY,
  output logic [DATA_WIDTH-1:0] INST_RDATA,
  output logic [1:0]            INST_RRESP,
  output logic                  INST_RLAST,
  output logic                  INST_RVALID,
  input  logic                  INST_RREADY,
  input  logic [ADDR_WIDTH-1:0] DATA_ARADDR,
  input  logic [7:0]            DATA_ARLEN,
  input  logic [2:0]            DATA_ARSIZE,
  input  logic [1:0]            DATA_ARBURST,
  input  logic                  DATA_ARVALID,
  output logic                  DATA_ARREADY,
  output logic [DATA_WIDTH-1:0] DATA_RDATA,
  output logic [1:0]            DATA_RRESP,
  output logic                  DATA_RLAST,
  output logic                  DATA_RVALID,
  input  logic                  DATA_RREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  arb_state_t state_q, state_d;
  logic       grant_inst, grant_data;

  axi_rd_arb_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk        (CLK),
    .rst_n      (RSTN),
    .inst_valid (INST_ARVALID),
    .data_valid (DATA_ARVALID),
    .arb_en     (state_q == ST_IDLE),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_inst)      state_d = ST_AR_INST;
        else if (grant_data) state_d = ST_AR_DATA;
      end
      ST_AR_INST: if (M_AXI_ARREADY) state_d = ST_R_INST;
      ST_AR_DATA: if (M_AXI_ARREADY) state_d = ST_R_DATA;
      ST_R_INST:  if (M_AXI_RVALID && INST_RREADY && M_AXI_RLAST) state_d = ST_IDLE;
      ST_R_DATA:  if (M_AXI_RVALID && DATA_RREADY && M_AXI_RLAST) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    INST_ARREADY  = grant_inst;
    DATA_ARREADY  = grant_data;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    INST_RVALID   = 1'b0;
    DATA_RVALID   = 1'b0;
    unique case (state_q)
      ST_AR_INST, ST_AR_DATA: M_AXI_ARVALID = 1'b1;
      ST_R_INST: begin
        M_AXI_RREADY = INST_RREADY;
        INST_RVALID  = M_AXI_RVALID;
      end
      ST_R_DATA: begin
        M_AXI_RREADY = DATA_RREADY;
        DATA_RVALID  = M_AXI_RVALID;
      end
      default: ;
    endcase
  end

  // AR fields are captured only at the grant, so a requester changing or
  // dropping its request afterwards cannot disturb the master AR channel.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      M_AXI_ARADDR  <= '0;
      M_AXI_ARLEN   <= '0;
      M_AXI_ARSIZE  <= '0;
      M_AXI_ARBURST <= '0;
    end else if (grant_inst) begin
      M_AXI_ARADDR  <= INST_ARADDR;
      M_AXI_ARLEN   <= INST_ARLEN;
      M_AXI_ARSIZE  <= INST_ARSIZE;
      M_AXI_ARBURST <= INST_ARBURST;
    end else if (grant_data) begin
      M_AXI_ARADDR  <= DATA_ARADDR;
      M_AXI_ARLEN   <= DATA_ARLEN;
      M_AXI_ARSIZE  <= DATA_ARSIZE;
      M_AXI_ARBURST <= DATA_ARBURST;
    end
  end

  assign INST_RDATA = M_AXI_RDATA;
  assign INST_RRESP = M_AXI_RRESP;
  assign INST_RLAST = M_AXI_RLAST;
  assign DATA_RDATA = M_AXI_RDATA;
  assign DATA_RRESP = M_AXI_RRESP;
  assign DATA_RLAST = M_AXI_RLAST;

`ifdef ARB_ERR_CAPTURE_EN
  logic err_beat;

  // RRESP[1] covers both SLVERR and DECERR.
  assign err_beat = M_AXI_RVALID && M_AXI_RREADY &&
                    ((M_AXI_RRESP & RESP_SLVERR) != 2'b00);

  // Only the first error is kept; a clear in the same cycle as a new error
  // lets the new error through.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      RD_ERR      <= 1'b0;
      RD_ERR_ADDR <= '0;
    end else if (err_beat && (!RD_ERR || RD_ERR_CLR)) begin
      RD_ERR      <= 1'b1;
      RD_ERR_ADDR <= M_AXI_ARADDR;
    end else if (RD_ERR_CLR) begin
      RD_ERR      <= 1'b0;
      RD_ERR_ADDR <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter (STARVE_LIMIT=2). Expected AR
// requests and R beats are queued when a request is driven and checked by a
// monitor as the DUT produces them. Define ARB_ERR_CAPTURE_EN to include
// the error-capture scenario.
module tb_axi_rd_arbiter;
  import axi_rd_arb_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  typedef struct {
    bit          port;
    logic [31:0] data;
  } beat_t;

  logic        CLK, RSTN;
  logic [31:0] INST_ARADDR, DATA_ARADDR, INST_RDATA, DATA_RDATA;
  logic [7:0]  INST_ARLEN, DATA_ARLEN;
  logic [2:0]  INST_ARSIZE, DATA_ARSIZE;
  logic [1:0]  INST_ARBURST, DATA_ARBURST, INST_RRESP, DATA_RRESP;
  logic        INST_ARVALID, DATA_ARVALID, INST_ARREADY, DATA_ARREADY;
  logic        INST_RLAST, DATA_RLAST, INST_RVALID, DATA_RVALID;
  logic        INST_RREADY, DATA_RREADY;
  logic [31:0] M_AXI_ARADDR, M_AXI_RDATA;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST, M_AXI_RRESP;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
`ifdef ARB_ERR_CAPTURE_EN
  logic        RD_ERR, RD_ERR_CLR;
  logic [31:0] RD_ERR_ADDR;
`endif

  int    n_tests = 0;
  int    n_fail  = 0;
  ar_t   exp_ar[$];
  beat_t exp_b[$];
  ar_t   mon_ar;
  beat_t mon_b;

  axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(2)) dut (
    .CLK(CLK), .RSTN(RSTN),
`ifdef ARB_ERR_CAPTURE_EN
    .RD_ERR(RD_ERR), .RD_ERR_ADDR(RD_ERR_ADDR), .RD_ERR_CLR(RD_ERR_CLR),
`endif
    .INST_ARADDR(INST_ARADDR), .INST_ARLEN(INST_ARLEN), .INST_ARSIZE(INST_ARSIZE),
    .INST_ARBURST(INST_ARBURST), .INST_ARVALID(INST_ARVALID), .INST_ARREADY(INST_ARREADY),
    .INST_RDATA(INST_RDATA), .INST_RRESP(INST_RRESP), .INST_RLAST(INST_RLAST),
    .INST_RVALID(INST_RVALID), .INST_RREADY(INST_RREADY),
    .DATA_ARADDR(DATA_ARADDR), .DATA_ARLEN(DATA_ARLEN), .DATA_ARSIZE(DATA_ARSIZE),
    .DATA_ARBURST(DATA_ARBURST), .DATA_ARVALID(DATA_ARVALID), .DATA_ARREADY(DATA_ARREADY),
    .DATA_RDATA(DATA_RDATA), .DATA_RRESP(DATA_RRESP), .DATA_RLAST(DATA_RLAST),
    .DATA_RVALID(DATA_RVALID), .DATA_RREADY(DATA_RREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Inst requests use size 2, data requests size 3, so the AR check also
  // tells the two requesters apart.
  task automatic set_req(input bit port, input logic [31:0] addr, input logic [7:0] len);
    if (!port) begin
      INST_ARADDR = addr; INST_ARLEN = len; INST_ARSIZE = 3'd2;
      INST_ARBURST = BURST_INCR; INST_ARVALID = 1'b1;
    end else begin
      DATA_ARADDR = addr; DATA_ARLEN = len; DATA_ARSIZE = 3'd3;
      DATA_ARBURST = BURST_INCR; DATA_ARVALID = 1'b1;
    end
  endtask

  task automatic push_exp(input bit port, input logic [31:0] addr, input logic [7:0] len);
    ar_t   a;
    beat_t b;
    a.addr = addr; a.len = len; a.size = port ? 3'd3 : 3'd2;
    exp_ar.push_back(a);
    for (int i = 0; i <= int'(len); i++) begin
      b.port = port; b.data = addr + 32'(i);
      exp_b.push_back(b);
    end
  endtask

  task automatic drive_req(input bit port, input logic [31:0] addr, input logic [7:0] len);
    set_req(port, addr, len);
    push_exp(port, addr, len);
  endtask

  // Slave side of one burst: optional AR stall, then len+1 beats of addr+i.
  task automatic serve(input logic [31:0] base, input int len, input int ar_stall,
                       input bit toggle, input int err_beat);
    int t;
    bit hs;
    t = 0;
    while (!M_AXI_ARVALID && t < 16) begin cyc(); t++; end
    chk("ar_valid_seen", M_AXI_ARVALID, 1);
    for (int s = 0; s < ar_stall; s++) begin
      chk("ar_stall_valid", M_AXI_ARVALID, 1);
      chk("ar_stall_addr", M_AXI_ARADDR, base);
      cyc();
    end
    M_AXI_ARREADY = 1'b1;
    cyc();
    M_AXI_ARREADY = 1'b0;
    for (int i = 0; i <= len; i++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = base + 32'(i);
      M_AXI_RLAST  = (i == len);
      M_AXI_RRESP  = (i == err_beat) ? RESP_SLVERR : 2'b00;
      t = 0; hs = 1'b0;
      while (!hs && t < 16) begin
        if (toggle) DATA_RREADY = ~DATA_RREADY;
        #1;
        if (toggle) chk("rready_track", M_AXI_RREADY, DATA_RREADY);
        hs = M_AXI_RREADY;
        cyc();
        t++;
      end
      chk("r_handshake", hs, 1);
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    M_AXI_RRESP  = 2'b00;
  endtask

  task automatic take_beat(input bit port, input logic [31:0] data);
    chk("beat_expected", exp_b.size() != 0, 1);
    if (exp_b.size() != 0) begin
      mon_b = exp_b.pop_front();
      chk("beat_port", port, mon_b.port);
      chk("beat_data", data, mon_b.data);
    end
  endtask

  // Monitor: values at the falling edge are what the next rising edge samples.
  always @(negedge CLK) begin
    if (RSTN) begin
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        chk("ar_expected", exp_ar.size() != 0, 1);
        if (exp_ar.size() != 0) begin
          mon_ar = exp_ar.pop_front();
          chk("ar_addr", M_AXI_ARADDR, mon_ar.addr);
          chk("ar_len", M_AXI_ARLEN, mon_ar.len);
          chk("ar_size", M_AXI_ARSIZE, mon_ar.size);
          chk("ar_burst", M_AXI_ARBURST, BURST_INCR);
        end
      end
      if (INST_RVALID && INST_RREADY) take_beat(1'b0, INST_RDATA);
      if (DATA_RVALID && DATA_RREADY) take_beat(1'b1, DATA_RDATA);
      if (M_AXI_RVALID) chk("rvalid_excl", INST_RVALID && DATA_RVALID, 0);
      if (M_AXI_RVALID && M_AXI_RREADY)
        chk("beat_routed", (INST_RVALID && INST_RREADY) || (DATA_RVALID && DATA_RREADY), 1);
      if (INST_ARREADY || DATA_ARREADY) chk("arready_excl", INST_ARREADY && DATA_ARREADY, 0);
    end
  end

  bit order [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    RSTN = 1'b0;
    INST_ARADDR = '0; INST_ARLEN = '0; INST_ARSIZE = '0; INST_ARBURST = '0; INST_ARVALID = 1'b0;
    DATA_ARADDR = '0; DATA_ARLEN = '0; DATA_ARSIZE = '0; DATA_ARBURST = '0; DATA_ARVALID = 1'b0;
    INST_RREADY = 1'b1; DATA_RREADY = 1'b1;
    M_AXI_ARREADY = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = '0; M_AXI_RLAST = 1'b0;
    M_AXI_RVALID = 1'b1;
`ifdef ARB_ERR_CAPTURE_EN
    RD_ERR_CLR = 1'b0;
`endif
    #12;
    chk("rst_arvalid", M_AXI_ARVALID, 0);
    chk("rst_rready", M_AXI_RREADY, 0);
    chk("rst_i_rvalid", INST_RVALID, 0);
    chk("rst_d_rvalid", DATA_RVALID, 0);
    chk("rst_i_arready", INST_ARREADY, 0);
    chk("rst_d_arready", DATA_ARREADY, 0);
    chk("rst_araddr", M_AXI_ARADDR, 0);
    chk("rst_arlen", M_AXI_ARLEN, 0);
`ifdef ARB_ERR_CAPTURE_EN
    chk("rst_rd_err", RD_ERR, 0);
    chk("rst_rd_err_addr", RD_ERR_ADDR, 0);
`endif
    M_AXI_RVALID = 1'b0;
    @(negedge CLK) RSTN = 1'b1;
    cyc(); cyc();

    // Inst only, 4 beats
    drive_req(1'b0, 32'h0000_1000, 8'd3);
    #1;
    chk("t1_i_arready_c0", INST_ARREADY, 1);
    chk("t1_d_arready_c0", DATA_ARREADY, 0);
    chk("t1_arvalid_c0", M_AXI_ARVALID, 0);
    cyc();
    INST_ARVALID = 1'b0;
    #1;
    chk("t1_arvalid_c1", M_AXI_ARVALID, 1);
    chk("t1_araddr_c1", M_AXI_ARADDR, 32'h0000_1000);
    chk("t1_i_arready_c1", INST_ARREADY, 0);
    serve(32'h0000_1000, 3, 0, 1'b0, -1);
    #1;
    chk("t1_idle_arvalid", M_AXI_ARVALID, 0);
    chk("t1_idle_rready", M_AXI_RREADY, 0);

    // Both held valid: inst, inst, data, inst, inst, data
    set_req(1'b0, 32'h0000_0100, 8'd0);
    set_req(1'b1, 32'h0000_0200, 8'd0);
    for (int k = 0; k < 6; k++) begin
      push_exp(order[k], order[k] ? 32'h0000_0200 : 32'h0000_0100, 8'd0);
      #1;
      chk($sformatf("prio_grant%0d", k), {INST_ARREADY, DATA_ARREADY},
          order[k] ? 64'h1 : 64'h2);
      cyc();
      serve(order[k] ? 32'h0000_0200 : 32'h0000_0100, 0, 0, 1'b0, -1);
    end
    INST_ARVALID = 1'b0;
    DATA_ARVALID = 1'b0;
    cyc();

    // Data burst with AR backpressure and toggling RREADY
    drive_req(1'b1, 32'h0000_3000, 8'd3);
    #1;
    chk("t3_d_arready", DATA_ARREADY, 1);
    cyc();
    DATA_ARVALID = 1'b0;
    DATA_ARADDR  = 32'hFFFF_FFF0;
    serve(32'h0000_3000, 3, 5, 1'b1, -1);
    DATA_RREADY = 1'b1;
    cyc();

    // Stray master RVALID while idle
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA  = 32'hDEAD_BEEF;
    #1;
    chk("t4_rready", M_AXI_RREADY, 0);
    chk("t4_i_rvalid", INST_RVALID, 0);
    chk("t4_d_rvalid", DATA_RVALID, 0);
    cyc();
    chk("t4_rready_held", M_AXI_RREADY, 0);
    M_AXI_RVALID = 1'b0;
    cyc();

    // Reset in the middle of a 4-beat inst burst
    drive_req(1'b0, 32'h0000_4000, 8'd3);
    #1;
    chk("t5_grant", INST_ARREADY, 1);
    cyc();
    INST_ARVALID = 1'b0;
    M_AXI_ARREADY = 1'b1;
    cyc();
    M_AXI_ARREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = 32'h0000_4000 + 32'(i);
      cyc();
    end
    M_AXI_RDATA = 32'h0000_4002;
    #1;
    chk("t5_rvalid_before", INST_RVALID, 1);
    RSTN = 1'b0;
    #1;
    chk("t5_rst_i_rvalid", INST_RVALID, 0);
    chk("t5_rst_rready", M_AXI_RREADY, 0);
    chk("t5_rst_arvalid", M_AXI_ARVALID, 0);
    chk("t5_rst_araddr", M_AXI_ARADDR, 0);
    M_AXI_RVALID = 1'b0;
    exp_b.delete();
    exp_ar.delete();
    cyc();
    @(negedge CLK) RSTN = 1'b1;
    cyc();
    drive_req(1'b0, 32'h0000_5000, 8'd1);
    #1;
    chk("t5_regrant", INST_ARREADY, 1);
    cyc();
    INST_ARVALID = 1'b0;
    serve(32'h0000_5000, 1, 0, 1'b0, -1);
    cyc();

`ifdef ARB_ERR_CAPTURE_EN
    // SLVERR on beat 1 of a data burst
    drive_req(1'b1, 32'h0000_2000, 8'd2);
    #1;
    chk("t6_grant", DATA_ARREADY, 1);
    cyc();
    DATA_ARVALID = 1'b0;
    serve(32'h0000_2000, 2, 0, 1'b0, 1);
    chk("t6_err_set", RD_ERR, 1);
    chk("t6_err_addr", RD_ERR_ADDR, 32'h0000_2000);
    repeat (3) cyc();
    chk("t6_err_hold", RD_ERR, 1);
    chk("t6_err_addr_hold", RD_ERR_ADDR, 32'h0000_2000);
    RD_ERR_CLR = 1'b1;
    cyc();
    RD_ERR_CLR = 1'b0;
    chk("t6_err_clr", RD_ERR, 0);
    chk("t6_err_clr_addr", RD_ERR_ADDR, 0);
`endif

    repeat (2) cyc();
    chk("ar_queue_empty", exp_ar.size(), 0);
    chk("beat_queue_empty", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
Read-channel arbiter between the instruction cache and the data cache on the shared AXI master. It replaces OR-merging of the two caches' AR outputs. It grants one burst at a time and holds the grant until the last read beat is accepted. The R channel is steered back only to the granted cache. Instruction reads have priority, and a starvation limit bounds how long data reads can wait.

Parameters:
ADDR_WIDTH, 32, AR address width.
DATA_WIDTH, 32, R data width.
STARVE_LIMIT, 8, consecutive inst grants with data pending before data is forced; 0 = strict inst priority.

Ports:
CLK  in  1  clock.
RSTN  in  1  asynchronous active-low reset.
INST_ARADDR/DATA_ARADDR  in  ADDR_WIDTH  requester read address.
INST_ARLEN/DATA_ARLEN  in  8  burst length minus one.
INST_ARSIZE/DATA_ARSIZE  in  3  beat size.
INST_ARBURST/DATA_ARBURST  in  2  burst type.
INST_ARVALID/DATA_ARVALID  in  1  request valid.
INST_ARREADY/DATA_ARREADY  out  1  request accepted.
INST_RDATA/DATA_RDATA  out  DATA_WIDTH  read beat data (broadcast of M_AXI_RDATA).
INST_RRESP/DATA_RRESP  out  2  broadcast of M_AXI_RRESP.
INST_RLAST/DATA_RLAST  out  1  broadcast of M_AXI_RLAST.
INST_RVALID/DATA_RVALID  out  1  beat valid, gated to the granted port.
INST_RREADY/DATA_RREADY  in  1  beat accept.
M_AXI_ARADDR  out  ADDR_WIDTH  registered address.
M_AXI_ARLEN  out  8  registered burst length.
M_AXI_ARSIZE  out  3  registered beat size.
M_AXI_ARBURST  out  2  registered burst type.
M_AXI_ARVALID  out  1  master address valid.
M_AXI_ARREADY  in  1  master address ready.
M_AXI_RDATA  in  DATA_WIDTH  master read data.
M_AXI_RRESP  in  2  master read response.
M_AXI_RLAST  in  1  master last beat.
M_AXI_RVALID  in  1  master beat valid.
M_AXI_RREADY  out  1  master beat ready.

Behaviour:
- Reset (RSTN low, async): state=IDLE, grant=none, starve counter=0. All ARVALID/ARREADY/RVALID/RREADY outputs are 0. AR registers are 0.
- The FSM has five states: IDLE, AR_INST, AR_DATA, R_INST, R_DATA.
- IDLE, winner selection:
  - inst wins if INST_ARVALID is high, unless DATA_ARVALID is high and starve counter == STARVE_LIMIT.
  - Otherwise data wins if DATA_ARVALID is high.
  - The winner's ARREADY is driven high combinationally in that same cycle.
  - Its ADDR/LEN/SIZE/BURST are latched, and the FSM moves to AR_x.
  - Only one ARREADY can be high per cycle.
- AR_x: M_AXI_ARVALID=1 with the latched fields held stable. On M_AXI_ARREADY the FSM moves to R_x. Both requester ARREADY outputs are 0.
- R_x: M_AXI_RREADY = x_RREADY and x_RVALID = M_AXI_RVALID; the other port's RVALID is 0. On M_AXI_RVALID & x_RREADY & M_AXI_RLAST the FSM returns to IDLE.
- Latency:
  - Request accepted at cycle 0; M_AXI_ARVALID high at cycle 1.
  - After the RLAST handshake, the earliest next grant is the following cycle (1 idle cycle between bursts).
- Starve counter:
  - At an inst grant while DATA_ARVALID is high, increment, saturating at STARVE_LIMIT.
  - At a data grant, clear to 0.
  - Width is clog2(STARVE_LIMIT+1), minimum 1.
- M_AXI_RVALID arriving in IDLE or AR_x: M_AXI_RREADY=0 and no port RVALID is asserted (beat is stalled, not dropped).
- A requester dropping ARVALID after it has been accepted has no effect.
- Reset mid-burst aborts to IDLE. The bus slave is reset by the same system reset.

Optional Feature:
ARB_ERR_CAPTURE_EN.
- Defined: adds outputs RD_ERR (1) and RD_ERR_ADDR (ADDR_WIDTH), both reset to 0.
- On the first handshaked beat with RRESP[1]=1 (SLVERR/DECERR), RD_ERR sets sticky and RD_ERR_ADDR captures the burst's latched ARADDR.
- Input RD_ERR_CLR (1) clears both. If clear and a new error occur in the same cycle, the new error wins.
- Undefined: these ports and registers are absent.

Decomposition:
- Package axi_rd_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_AR_INST, ST_AR_DATA, ST_R_INST, ST_R_DATA;
  - AXI constants BURST_INCR = 2'b01 and RESP_SLVERR = 2'b10.
- One sub-module, axi_rd_arb_sel: combinational winner select plus the starve counter register.

Test Plan:
- Inst only: INST_ARVALID with ADDR=0x0000_1000, LEN=3. Expect INST_ARREADY at cycle 0 and M_AXI_ARADDR=0x1000 with ARVALID at cycle 1. 4 beats appear only on INST_RVALID; IDLE after RLAST.
- Simultaneous requests, STARVE_LIMIT=2, both held valid: grant order inst, inst, data, inst, inst, data.
- Backpressure: M_AXI_ARREADY low 5 cycles. ARVALID/ADDR stay stable; then DATA_RREADY toggled per beat. M_AXI_RREADY tracks DATA_RREADY and no beat is lost.
- Stray M_AXI_RVALID=1 in IDLE: M_AXI_RREADY=0 and both port RVALIDs are 0.
- RSTN pulsed low mid-burst (beat 2 of 4): all outputs 0 immediately; after release the FSM is in IDLE and accepts a new request.
- With ARB_ERR_CAPTURE_EN: RRESP=2'b10 on beat 1 of burst ADDR=0x2000. Expect RD_ERR=1 and RD_ERR_ADDR=0x2000, held until RD_ERR_CLR.
